// File: rtl/nina_dom_and_d1_k1.sv
// Two-stage, first-order masked DOM AND with K+1 redundant copies per share.
// Optional macro NINA_CHECK_EN adds the per-share copy-consistency check and alarm FSM.
module nina_dom_and_d1_k1 #(
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [K:0]   port_a_0,
    input  logic [K:0]   port_a_1,
    input  logic [K:0]   port_b_0,
    input  logic [K:0]   port_b_1,
    input  logic [K:0]   rand_z,
    output logic [K:0]   port_c_0,
    output logic [K:0]   port_c_1,
    output logic         out_valid,
    output logic         fault_flag
);

    localparam int W = K + 1;

    logic [W-1:0] prod_00, prod_01, prod_11, prod_10;
    logic [W-1:0] s00_d, s01_d, s11_d, s10_d;
    logic [W-1:0] s00_q, s01_q, s11_q, s10_q;
    logic         v1_d, v1_q;
    logic [W-1:0] c0_d, c1_d, c0_q, c1_q;
    logic         out_valid_d, out_valid_q;

    // Cross-domain products stay separate until after the register so that
    // the glitch-prone recombination never sees both shares combinationally.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_copy
            assign prod_00[gi] = port_a_0[gi] & port_b_0[gi];
            assign prod_01[gi] = port_a_0[gi] & port_b_1[gi];
            assign prod_11[gi] = port_a_1[gi] & port_b_1[gi];
            assign prod_10[gi] = port_a_1[gi] & port_b_0[gi];
        end
    endgenerate

    always_comb begin
        s00_d       = prod_00;
        s01_d       = prod_01 ^ rand_z;
        s11_d       = prod_11;
        s10_d       = prod_10 ^ rand_z;
        v1_d        = in_valid;
        // Result registers only move on a valid beat and hold otherwise.
        c0_d        = v1_q ? (s00_q ^ s01_q) : c0_q;
        c1_d        = v1_q ? (s11_q ^ s10_q) : c1_q;
        out_valid_d = v1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s00_q       <= '0;
            s01_q       <= '0;
            s11_q       <= '0;
            s10_q       <= '0;
            v1_q        <= 1'b0;
            c0_q        <= '0;
            c1_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s00_q       <= s00_d;
            s01_q       <= s01_d;
            s11_q       <= s11_d;
            s10_q       <= s10_d;
            v1_q        <= v1_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef NINA_CHECK_EN
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ALARM = 1'b1
    } state_t;

    state_t state_d, state_q;
    logic   err;

    // Each share is checked on its own; shares are never brought together here.
    assign err = out_valid_q & ((c0_q != {W{c0_q[0]}}) | (c1_q != {W{c1_q[0]}}));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (err) state_d = ST_ALARM;
            ST_ALARM: state_d = ST_ALARM;
            default:  state_d = ST_ALARM;
        endcase
    end

    // The err cycle itself still shows raw data; suppression starts one cycle later.
    always_comb begin
        fault_flag = 1'b0;
        port_c_0   = c0_q;
        port_c_1   = c1_q;
        out_valid  = out_valid_q;
        if (state_q == ST_ALARM) begin
            fault_flag = 1'b1;
            port_c_0   = '0;
            port_c_1   = '0;
            out_valid  = 1'b0;
        end
    end
`else
    always_comb begin
        fault_flag = 1'b0;
        port_c_0   = c0_q;
        port_c_1   = c1_q;
        out_valid  = out_valid_q;
    end
`endif

endmodule

// File: doc/nina_dom_and_d1_k1.md
Name: nina_dom_and_d1_k1

Overview:
- First-order (d=1) masked AND gadget with fault order k=1; the registered nonlinear stage downstream of the share-wise NINA XOR layer in the masked S-box datapath.
- Each share is carried as K+1 redundant copies, one bit per copy.
- Computes a two-share DOM-independent AND on every copy using fresh randomness.
- Checks copy consistency per share and suppresses outputs on a detected fault.

Parameters:
- K, 1, fault order; every share and the randomness bus are K+1 bits wide, bit j = copy j.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input shares and randomness valid this cycle
- port_a_0  input  K+1  share 0 of operand a, one bit per copy
- port_a_1  input  K+1  share 1 of operand a
- port_b_0  input  K+1  share 0 of operand b
- port_b_1  input  K+1  share 1 of operand b
- rand_z  input  K+1  fresh random bit; all copies carry the same value
- port_c_0  output  K+1  share 0 of a AND b, registered
- port_c_1  output  K+1  share 1 of a AND b, registered
- out_valid  output  1  port_c_* valid
- fault_flag  output  1  sticky fault indication

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all registers cleared on the clock edge with rst=1. port_c_0=0, port_c_1=0, out_valid=0, fault_flag=0, FSM=RUN. rst mid-stream discards all in-flight data; no output is produced for inputs accepted before reset.
- Stage 1 (edge after in_valid=1), per copy j, each product in its own register:
  - s00 = a0&b0
  - s01 = (a0&b1)^z
  - s11 = a1&b1
  - s10 = (a1&b0)^z
  - v1 <= in_valid.
- Stage 1 holds no combinational mixing of share 0 and share 1 before the register.
- Stage 2:
  - c0[j] <= s00^s01
  - c1[j] <= s11^s10
  - out_valid <= v1.
- Latency: exactly 2 cycles. Throughput: 1 per cycle, no backpressure.
- When in_valid=0, stage registers still load, but valid bits clear; port_c_* hold the last valid value.
- Consistency check: computed on stage-2 register outputs, per share only. Shares are never combined.
  - err = out_valid & ((c0 not all-equal across copies) | (c1 not all-equal across copies)).
- FSM:
  - RUN -> ALARM when err=1.
  - ALARM is absorbing until rst.
- In ALARM:
  - fault_flag=1.
  - port_c_0 and port_c_1 forced to 0, starting the cycle after err.
  - out_valid forced to 0.
- On the err cycle itself, outputs show the raw faulty values. The consumer must qualify data with fault_flag one cycle later.
- Simultaneous rst and err: rst wins, FSM=RUN.

Optional Feature:
- Macro: NINA_CHECK_EN
- Defined: consistency comparator, FSM, and output suppression are present, as above.
- Undefined: no comparator or FSM; fault_flag tied to 0; outputs are never suppressed. The datapath and its 2-cycle latency are unchanged.

Test Plan:
1. Basic AND, z=0: a0=11, a1=00, b0=00, b1=11, rand_z=00, in_valid=1 for one cycle -> 2 cycles later port_c_0=11, port_c_1=00, out_valid=1 for one cycle, fault_flag=0.
2. Remasking, z=1: same operands, rand_z=11 -> port_c_0=00, port_c_1=11. Also sweep all 16 unmasked/mask combinations, both z values: (c0^c1) per copy equals (a0^a1)&(b0^b1).
3. Streaming: 8 back-to-back valid inputs -> 8 consecutive out_valid cycles, in order, latency 2. An in_valid gap of 1 cycle produces exactly one out_valid=0 bubble.
4. Fault injection (NINA_CHECK_EN defined): a0=01, a1=00, b0=00, b1=11, rand_z=00 -> c0=01 on cycle 2. On cycle 3: fault_flag=1, port_c_*=00, out_valid=0. A following valid input keeps outputs at 0.
5. Reset recovery: in ALARM, assert rst one cycle -> next cycle fault_flag=0, outputs 0. Scenario 1 then passes with latency 2. rst asserted with inputs in flight -> no out_valid for them.
6. Macro off: repeat scenario 4 -> port_c_0=01 on cycle 2, fault_flag stays 0, subsequent results unsuppressed.
